// File: rtl/montgomery_encode_if.sv
// Handshake bundle for montgomery_encode: operand request side and result side.
// MONT_ENC_ERR_EN adds the out_err result flag.
interface montgomery_encode_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] x;
   logic [DATA_WIDTH-1:0] modulant;
   logic [DATA_WIDTH-1:0] R_div_two;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out;
`ifdef MONT_ENC_ERR_EN
   logic                  out_err;
`endif

   modport master (
      output in_valid, x, modulant, R_div_two, out_ready,
      input  in_ready, out_valid, out
`ifdef MONT_ENC_ERR_EN
      , input out_err
`endif
   );

   modport slave (
      input  in_valid, x, modulant, R_div_two, out_ready,
      output in_ready, out_valid, out
`ifdef MONT_ENC_ERR_EN
      , output out_err
`endif
   );
endinterface

// File: rtl/montgomery_encode.sv
// Montgomery-domain encoder: out = x*R mod n by repeated modular doubling, one per clock.
// MONT_ENC_ERR_EN enables input legality flagging on out_err (out forced to 0 on error).
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | in_ready=1, waiting for an operand
// S_RUN  | one modular doubling per cycle while cnt != 0
// S_DONE | out_valid=1, result held until out_ready
module montgomery_encode #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   montgomery_encode_if.slave   bus
);
   localparam int W = DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [W:0]     y_q, y_d;
   logic [W-1:0]   n_q, n_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]   out_q, out_d;
`ifdef MONT_ENC_ERR_EN
   logic           err_q, err_d;
   logic           err_in;
`endif

   logic [W:0]     x_ext;
   logic [W:0]     m_ext;
   logic [W:0]     n_ext;
   logic [W:0]     y_load;
   logic [W:0]     y_dbl;
   logic [W:0]     y_dbl_red;

   // y stays below n after each step, so the shifted-out top bit is always zero
   assign x_ext     = {1'b0, bus.x};
   assign m_ext     = {1'b0, bus.modulant};
   assign n_ext     = {1'b0, n_q};
   assign y_load    = (x_ext >= m_ext) ? (x_ext - m_ext) : x_ext;
   assign y_dbl     = y_q << 1;
   assign y_dbl_red = (y_dbl >= n_ext) ? (y_dbl - n_ext) : y_dbl;

`ifdef MONT_ENC_ERR_EN
   assign err_in = (bus.modulant[0] == 1'b0) || (bus.modulant < W'(3)) ||
                   (bus.x >= bus.modulant);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         y_q     <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
`ifdef MONT_ENC_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
`ifdef MONT_ENC_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
`ifdef MONT_ENC_ERR_EN
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               n_d     = bus.modulant;
               cnt_d   = bus.R_div_two;
               y_d     = y_load;
`ifdef MONT_ENC_ERR_EN
               err_d   = err_in;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q != '0) begin
               y_d   = y_dbl_red;
               cnt_d = cnt_q >> 1;
            end else begin
`ifdef MONT_ENC_ERR_EN
               out_d = err_q ? '0 : y_q[W-1:0];
`else
               out_d = y_q[W-1:0];
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.out       = out_q;
`ifdef MONT_ENC_ERR_EN
   assign bus.out_err   = err_q;
`endif

endmodule

// File: tb/tb_montgomery_encode.sv
// Self-checking bench for montgomery_encode: vector table, backpressure, reset abort, round trip.
module tb_montgomery_encode;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   montgomery_encode_if #(.DATA_WIDTH(W)) bus ();
   montgomery_encode #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [7:0] x;
      logic [7:0] n;
      logic [7:0] r;
      logic [7:0] exp_out;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   typedef struct {
      logic [7:0] out;
      logic       err;
      int         lat;
   } sb_t;

   sb_t sbq[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int bitlen(input int v);
      int b = 0;
      while (v != 0) begin b++; v = v >> 1; end
      return b;
   endfunction

   // Reference: x*R mod n with the single load subtract, independent of the doubling loop
   function automatic sb_t model(input logic [7:0] xx, input logic [7:0] nn, input logic [7:0] rr);
      sb_t e;
      int xr, rv, nv;
      nv    = int'(nn);
      xr    = (int'(xx) >= nv) ? int'(xx) - nv : int'(xx);
      rv    = (rr == 0) ? 1 : 2 * int'(rr);
      e.err = (nn[0] == 1'b0) || (nn < 8'd3) || (xx >= nn);
      e.out = 8'((xr * rv) % nv);
`ifdef MONT_ENC_ERR_EN
      if (e.err) e.out = 8'd0;
`endif
      e.lat = bitlen(int'(rr)) + 1;
      return e;
   endfunction

   task automatic run_op(input logic [7:0] xx, input logic [7:0] nn, input logic [7:0] rr,
                         input int hold, input string tag, output logic [7:0] got);
      sb_t e;
      int  lat;
      logic [7:0] held;
      got = '0;
      @(negedge clk);
      chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.x         = xx;
      bus.modulant  = nn;
      bus.R_div_two = rr;
      sbq.push_back(model(xx, nn, rr));
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.x         = 8'($urandom);
      bus.modulant  = 8'($urandom);
      bus.R_div_two = 8'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = sbq.pop_front();
      if (!bus.out_valid) begin
         chk({tag, " timeout"}, 32'(lat), 32'(e.lat));
         return;
      end
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({tag, " out"}, 32'(bus.out), 32'(e.out));
`ifdef MONT_ENC_ERR_EN
      chk({tag, " out_err"}, 32'(bus.out_err), 32'(e.err));
`endif
      got  = bus.out;
      held = bus.out;
      for (int i = 0; i < hold; i++) begin
         if (i == 2) begin
            bus.in_valid = 1'b1;
            bus.x = 8'd1; bus.modulant = 8'd7; bus.R_div_two = 8'd1;
         end
         if (i == 3) bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
         chk({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
         chk({tag, " hold out"}, 32'(bus.out), 32'(held));
         chk({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk({tag, " in_ready on release"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, " out_valid after release"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " idle after release"}, 32'(bus.in_ready), 32'd1);
   endtask

   vec_t vecs[$];
   logic [7:0] got;
   int t;
   int stray;

   initial begin
      vecs.push_back('{x:8'd5,   n:8'd13,  r:8'd8,   exp_out:8'd2,   exp_err:1'b0, exp_lat:5});
      vecs.push_back('{x:8'd12,  n:8'd13,  r:8'd8,   exp_out:8'd10,  exp_err:1'b0, exp_lat:5});
      vecs.push_back('{x:8'd0,   n:8'd13,  r:8'd8,   exp_out:8'd0,   exp_err:1'b0, exp_lat:5});
      vecs.push_back('{x:8'd7,   n:8'd13,  r:8'd0,   exp_out:8'd7,   exp_err:1'b0, exp_lat:1});
      vecs.push_back('{x:8'd1,   n:8'd13,  r:8'd1,   exp_out:8'd2,   exp_err:1'b0, exp_lat:2});
      vecs.push_back('{x:8'd250, n:8'd251, r:8'd128, exp_out:8'd246, exp_err:1'b0, exp_lat:9});
      vecs.push_back('{x:8'd200, n:8'd255, r:8'd64,  exp_out:8'd100, exp_err:1'b0, exp_lat:8});
      vecs.push_back('{x:8'd2,   n:8'd3,   r:8'd2,   exp_out:8'd2,   exp_err:1'b0, exp_lat:3});
`ifdef MONT_ENC_ERR_EN
      vecs.push_back('{x:8'd20,  n:8'd13,  r:8'd0,   exp_out:8'd0,   exp_err:1'b1, exp_lat:1});
      vecs.push_back('{x:8'd5,   n:8'd12,  r:8'd8,   exp_out:8'd0,   exp_err:1'b1, exp_lat:5});
      vecs.push_back('{x:8'd13,  n:8'd13,  r:8'd8,   exp_out:8'd0,   exp_err:1'b1, exp_lat:5});
`else
      vecs.push_back('{x:8'd20,  n:8'd13,  r:8'd0,   exp_out:8'd7,   exp_err:1'b0, exp_lat:1});
`endif

      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.x = '0; bus.modulant = '0; bus.R_div_two = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out", 32'(bus.out), 32'd0);
`ifdef MONT_ENC_ERR_EN
      chk("reset out_err", 32'(bus.out_err), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].x, vecs[i].n, vecs[i].r, 0, $sformatf("vec%0d", i), got);
         chk($sformatf("vec%0d table out", i), 32'(got), 32'(vecs[i].exp_out));
      end

      run_op(8'd5, 8'd13, 8'd8, 10, "backpressure", got);
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid || !bus.in_ready) stray++;
      end
      chk("no result from ignored pulse", 32'(stray), 32'd0);

      @(negedge clk);
      bus.in_valid = 1'b1; bus.x = 8'd5; bus.modulant = 8'd13; bus.R_div_two = 8'd128;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort out", 32'(bus.out), 32'd0);
      reset = 1'b0;
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) stray++;
      end
      chk("abort emits nothing", 32'(stray), 32'd0);
      run_op(8'd250, 8'd251, 8'd128, 0, "post-abort", got);

      // Round trip: reduce the encoded value back out with R=256 and expect x
      for (int i = 0; i < 200; i++) begin
         logic [7:0] nn, xx;
         nn = 8'($urandom_range(3, 255)) | 8'd1;
         xx = 8'($urandom_range(0, int'(nn) - 1));
         run_op(xx, nn, 8'd128, 0, "roundtrip", got);
         t = int'(got);
         for (int k = 0; k < 8; k++) begin
            if (t[0]) t = t + int'(nn);
            t = t >> 1;
         end
         if (t >= int'(nn)) t = t - int'(nn);
         chk($sformatf("roundtrip n=%0d x=%0d", nn, xx), 32'(t), 32'(xx));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
